// File: rtl/io_bus_fabric_if.sv
// io_bus_fabric_if: bundle of CPU-side handshake and slot-side broadcast/select signals.
// Latency: none (wires only).
// Backpressure: carries BUSY; the CPU side holds off REQ while BUSY is high.
// Ports: master = CPU/peripheral side (drives REQ/A/DI/R_W_n/SLOT_DO), slave = fabric.
interface io_bus_fabric_if #(
   parameter int NUM_SLOTS  = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic                            REQ;
   logic [ADDR_WIDTH-1:0]           A;
   logic [DATA_WIDTH-1:0]           DI;
   logic                            R_W_n;
   logic [DATA_WIDTH-1:0]           DO;
   logic                            READY;
   logic                            BUSY;
   logic [NUM_SLOTS-1:0]            SEL_n;
   logic                            WE;
   logic [DATA_WIDTH-1:0]           WDATA;
   logic [ADDR_WIDTH-1:0]           SLOT_ADDR;
   logic [NUM_SLOTS*DATA_WIDTH-1:0] SLOT_DO;
   logic                            ERR;
   logic [ADDR_WIDTH-1:0]           ERR_ADDR;
   logic [7:0]                      ERR_COUNT;

   modport master (
      output REQ, A, DI, R_W_n, SLOT_DO,
      input  DO, READY, BUSY, SEL_n, WE, WDATA, SLOT_ADDR, ERR, ERR_ADDR, ERR_COUNT
   );

   modport slave (
      input  REQ, A, DI, R_W_n, SLOT_DO,
      output DO, READY, BUSY, SEL_n, WE, WDATA, SLOT_ADDR, ERR, ERR_ADDR, ERR_COUNT
   );
endinterface

// File: rtl/io_bus_fabric.sv
// io_bus_fabric: address decoder, chip-select/write-strobe generator and read-data mux for up to 8 slots.
// Latency: mapped access -> READY in cycle W+2 after accept (W = slot wait count); unmapped -> cycle 1.
// Backpressure: BUSY high while a slot is selected; REQ seen during BUSY is dropped (no queueing).
// Ports: CLK, RESET (sync, active high); bus (slave modport) with CPU handshake, slot selects, error log.
module io_bus_fabric #(
   parameter int NUM_SLOTS  = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter logic [NUM_SLOTS*ADDR_WIDTH-1:0] SLOT_BASE = {16'hE000, 16'h0000, 16'hC000, 16'h0000},
   parameter logic [NUM_SLOTS*ADDR_WIDTH-1:0] SLOT_MASK = {16'hE000, 16'hE000, 16'hE000, 16'h0000},
   parameter logic [NUM_SLOTS*4-1:0]          SLOT_WAIT = {4'd0, 4'd0, 4'd2, 4'd0},
   parameter logic [DATA_WIDTH-1:0]           OPEN_BUS  = 8'hA5
) (
   input  logic             CLK,
   input  logic             RESET,
   io_bus_fabric_if.slave   bus
);

   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [IDX_W-1:0]      slot_q;
   logic                  rw_q;
   logic                  busy_q;
   logic                  ready_q;
   logic                  we_q;
   logic                  err_q;
   logic [NUM_SLOTS-1:0]  sel_n_q;
   logic [DATA_WIDTH-1:0] do_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [ADDR_WIDTH-1:0] slot_addr_q;
   logic [ADDR_WIDTH-1:0] err_addr_q;
   logic [7:0]            err_cnt_q;

   logic                  hit_d;
   logic [IDX_W-1:0]      hit_idx_d;
   logic [3:0]            hit_wait_d;
   logic [DATA_WIDTH-1:0] slot_rdata;

   // Scan from the highest slot down so the lowest matching index is the one left standing.
   always_comb begin
      hit_d      = 1'b0;
      hit_idx_d  = '0;
      hit_wait_d = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if ((SLOT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
             ((bus.A & SLOT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
              (SLOT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLOT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
            hit_d      = 1'b1;
            hit_idx_d  = IDX_W'(i);
            hit_wait_d = SLOT_WAIT[i*4 +: 4];
         end
      end
   end

   assign slot_rdata = bus.SLOT_DO[slot_q*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         slot_q      <= '0;
         rw_q        <= 1'b1;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         sel_n_q     <= '1;
         do_q        <= OPEN_BUS;
         wdata_q     <= '0;
         slot_addr_q <= '0;
         err_addr_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         case (state_q)
            ST_ACCESS: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  sel_n_q <= '1;
                  if (rw_q) do_q <= slot_rdata;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
                  // Strobe is registered, so raise it one edge ahead of the final select cycle.
                  if ((cnt_q == 4'd1) && !rw_q) we_q <= 1'b1;
               end
            end
            default: begin
               // IDLE and DONE both accept, which gives back-to-back transfers from DONE.
               state_q <= ST_IDLE;
               sel_n_q <= '1;
               if (bus.REQ) begin
                  slot_addr_q <= bus.A;
                  wdata_q     <= bus.DI;
                  rw_q        <= bus.R_W_n;
                  if (hit_d) begin
                     state_q <= ST_ACCESS;
                     busy_q  <= 1'b1;
                     cnt_q   <= hit_wait_d;
                     slot_q  <= hit_idx_d;
                     sel_n_q <= ~(NUM_SLOTS'(1) << hit_idx_d);
                     we_q    <= !bus.R_W_n && (hit_wait_d == 4'd0);
                  end else begin
                     state_q    <= ST_DONE;
                     ready_q    <= 1'b1;
                     err_q      <= 1'b1;
                     err_addr_q <= bus.A;
                     if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                     if (bus.R_W_n) do_q <= OPEN_BUS;
                  end
               end
            end
         endcase
      end
   end

   assign bus.DO        = do_q;
   assign bus.READY     = ready_q;
   assign bus.BUSY      = busy_q;
   assign bus.SEL_n     = sel_n_q;
   assign bus.WE        = we_q;
   assign bus.WDATA     = wdata_q;
   assign bus.SLOT_ADDR = slot_addr_q;
   assign bus.ERR       = err_q;
   assign bus.ERR_ADDR  = err_addr_q;
   assign bus.ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_io_bus_fabric.sv
// tb_io_bus_fabric: randomized + directed stimulus, scoreboard of expected completions, negedge monitor.
// Latency: n/a.
// Backpressure: driver spaces requests by the model's own expected completion time.
module tb_io_bus_fabric;

   localparam logic [63:0] T_BASE = {16'hE000, 16'h0000, 16'hC000, 16'h0000};
   localparam logic [63:0] T_MASK = {16'hE000, 16'hE000, 16'hE000, 16'hFF00};
   localparam logic [15:0] T_WAIT = {4'd0, 4'd1, 4'd2, 4'd15};

   // Reference memory map, slot index = array index.
   int m_base[4] = '{32'h0000, 32'hC000, 32'h0000, 32'hE000};
   int m_mask[4] = '{32'hFF00, 32'hE000, 32'hE000, 32'hE000};
   int m_wait[4] = '{15, 2, 1, 0};

   typedef struct {
      int          issue;
      int          lat;
      int          slot;
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  wdat;
      logic [7:0]  do_v;
      logic        err;
      logic [15:0] err_addr;
      int          err_cnt;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   int   cyc = 0;
   logic rst_seen = 1'b1;
   int   total = 0;
   int   bad = 0;

   exp_t sb[$];
   logic [7:0]  m_do = 8'hA5;
   int          m_err_cnt = 0;
   logic [15:0] m_err_addr = 16'h0;

   io_bus_fabric_if #(.NUM_SLOTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(8)) bus();

   io_bus_fabric #(
      .NUM_SLOTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(8),
      .SLOT_BASE(T_BASE), .SLOT_MASK(T_MASK), .SLOT_WAIT(T_WAIT), .OPEN_BUS(8'hA5)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      cyc      <= cyc + 1;
      rst_seen <= RESET;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int model_slot(input logic [15:0] a);
      for (int i = 0; i < 4; i++)
         if (m_mask[i] != 0 && ((32'(a) ^ m_base[i]) & m_mask[i]) == 0) return i;
      return -1;
   endfunction

   // ---------------- monitor ----------------
   int          sel_cnt = 0, we_cnt = 0, we_pos = 0, busy_bad = 0;
   logic [3:0]  last_sel = 4'hF;
   logic [7:0]  we_dat = 8'h0;
   logic [15:0] we_addr = 16'h0;
   exp_t        me;

   always @(negedge CLK) begin
      if (rst_seen) begin
         sel_cnt = 0; we_cnt = 0; we_pos = 0; busy_bad = 0; last_sel = 4'hF;
      end else begin
         if (bus.SEL_n != 4'hF) begin
            sel_cnt++;
            last_sel = bus.SEL_n;
            if (bus.BUSY !== 1'b1) busy_bad++;
         end else if (bus.BUSY !== 1'b0) begin
            busy_bad++;
         end
         if (bus.WE) begin
            we_cnt++;
            we_pos  = sel_cnt;
            we_dat  = bus.WDATA;
            we_addr = bus.SLOT_ADDR;
         end
         if (bus.READY) begin
            if (sb.size() == 0) begin
               check("ready_without_txn", 32'(bus.READY), 32'd0);
            end else begin
               me = sb.pop_front();
               check("latency",   cyc - me.issue, me.lat);
               check("do",        32'(bus.DO), 32'(me.do_v));
               check("err",       32'(bus.ERR), 32'(me.err));
               check("err_addr",  32'(bus.ERR_ADDR), 32'(me.err_addr));
               check("err_count", 32'(bus.ERR_COUNT), me.err_cnt);
               check("slot_addr", 32'(bus.SLOT_ADDR), 32'(me.addr));
               check("wdata",     32'(bus.WDATA), 32'(me.wdat));
               check("busy",      busy_bad + 32'(bus.BUSY), 0);
               check("sel_cycles", sel_cnt, (me.slot >= 0) ? m_wait[me.slot] + 1 : 0);
               check("we_count",  we_cnt, (me.slot >= 0 && !me.rw) ? 1 : 0);
               if (me.slot >= 0)
                  check("sel_pattern", 32'(last_sel), 32'(4'hF ^ (4'b0001 << me.slot)));
               if (me.slot >= 0 && !me.rw) begin
                  check("we_position", we_pos, m_wait[me.slot] + 1);
                  check("we_data",     32'(we_dat), 32'(me.wdat));
                  check("we_addr",     32'(we_addr), 32'(me.addr));
               end
            end
            sel_cnt = 0; we_cnt = 0; we_pos = 0; busy_bad = 0; last_sel = 4'hF;
         end
      end
   end

   // ---------------- driver ----------------
   // Called on a negedge; returns on the negedge of the expected READY cycle.
   task automatic issue(input logic [15:0] addr, input logic [7:0] data, input logic rw,
                        input logic [31:0] sdo, input logic poke);
      exp_t e;
      int   s;
      s = model_slot(addr);
      bus.REQ = 1'b1; bus.A = addr; bus.DI = data; bus.R_W_n = rw; bus.SLOT_DO = sdo;
      e.issue = cyc; e.slot = s; e.rw = rw; e.addr = addr; e.wdat = data;
      if (s >= 0) begin
         e.lat = m_wait[s] + 2;
         e.err = 1'b0;
         if (rw) m_do = sdo[s*8 +: 8];
      end else begin
         e.lat = 1;
         e.err = 1'b1;
         m_err_cnt  = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
         m_err_addr = addr;
         if (rw) m_do = 8'hA5;
      end
      e.do_v = m_do; e.err_addr = m_err_addr; e.err_cnt = m_err_cnt;
      sb.push_back(e);
      @(negedge CLK);
      if (poke && s >= 0) begin
         // Request while the slot is being accessed must be dropped.
         bus.REQ = 1'b1; bus.A = 16'($urandom); bus.R_W_n = 1'($urandom);
         @(negedge CLK);
         bus.REQ = 1'b0;
         repeat (e.lat - 2) @(negedge CLK);
      end else begin
         bus.REQ = 1'b0;
         repeat (e.lat - 1) @(negedge CLK);
      end
   endtask

   logic [15:0] ra;
   int          we_seen, rdy_seen;

   initial begin
      bus.REQ = 1'b0; bus.A = '0; bus.DI = '0; bus.R_W_n = 1'b1; bus.SLOT_DO = '0;
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;

      check("rst_do",        32'(bus.DO), 32'h A5);
      check("rst_ready",     32'(bus.READY), 0);
      check("rst_busy",      32'(bus.BUSY), 0);
      check("rst_sel_n",     32'(bus.SEL_n), 32'hF);
      check("rst_we",        32'(bus.WE), 0);
      check("rst_wdata",     32'(bus.WDATA), 0);
      check("rst_slot_addr", 32'(bus.SLOT_ADDR), 0);
      check("rst_err",       32'(bus.ERR), 0);
      check("rst_err_addr",  32'(bus.ERR_ADDR), 0);
      check("rst_err_count", 32'(bus.ERR_COUNT), 0);

      // Directed cases from the memory map.
      issue(16'hE123, 8'h00, 1'b1, 32'h3C00_1122, 1'b0);   // slot3, wait 0
      @(negedge CLK);
      issue(16'hC001, 8'h55, 1'b0, 32'h0, 1'b0);           // slot1 write, wait 2
      @(negedge CLK);
      issue(16'h4000, 8'h00, 1'b1, 32'h0, 1'b0);           // unmapped read
      issue(16'h0010, 8'h00, 1'b1, 32'h0033_4477, 1'b0);   // slot0 and slot2 overlap, wait 15
      issue(16'hE200, 8'h00, 1'b1, 32'h9900_0000, 1'b1);   // REQ poked during ACCESS
      issue(16'hC0FF, 8'h6B, 1'b0, 32'h0, 1'b1);           // issued in DONE cycle
      issue(16'h1234, 8'h00, 1'b1, 32'h0058_0000, 1'b0);   // slot2, wait 1

      // Saturating error counter, back-to-back unmapped accesses.
      for (int i = 0; i < 300; i++)
         issue(16'(16'h2000 + $urandom_range(0, 16'h9FFF)), 8'($urandom), 1'($urandom), $urandom, 1'b0);
      check("err_count_sat", 32'(bus.ERR_COUNT), 32'd255);

      // Park a non-open-bus value in DO, then reset in cycle 2 of a wait-2 write.
      issue(16'hE000, 8'h00, 1'b1, 32'h7700_0000, 1'b0);
      @(negedge CLK);
      bus.REQ = 1'b1; bus.A = 16'hC001; bus.DI = 8'h55; bus.R_W_n = 1'b0;
      @(negedge CLK);
      bus.REQ = 1'b0;
      @(negedge CLK);
      check("rst_mid_sel_before", 32'(bus.SEL_n), 32'hD);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      m_do = 8'hA5; m_err_cnt = 0; m_err_addr = 16'h0;
      check("rst_mid_sel_n", 32'(bus.SEL_n), 32'hF);
      check("rst_mid_busy",  32'(bus.BUSY), 0);
      check("rst_mid_do",    32'(bus.DO), 32'hA5);
      check("rst_mid_errcnt", 32'(bus.ERR_COUNT), 0);
      we_seen = 0; rdy_seen = 0;
      for (int i = 0; i < 5; i++) begin
         we_seen  += 32'(bus.WE);
         rdy_seen += 32'(bus.READY);
         @(negedge CLK);
      end
      check("rst_mid_no_we",    we_seen, 0);
      check("rst_mid_no_ready", rdy_seen, 0);

      // Randomized traffic with random gaps (gap 0 = issue in DONE).
      for (int i = 0; i < 200; i++) begin
         ra = ($urandom_range(0, 4) == 0) ? {8'h00, 8'($urandom)} : 16'($urandom);
         issue(ra, 8'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
      check("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
